// File: rtl/score_tracker_pkg.sv
// Shared game definitions: FSM state encodings, score width and the saturating increment.
package score_tracker_pkg;

    localparam int unsigned SCORE_W = 7;

    typedef logic [SCORE_W-1:0] score_t;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] OVER = 2'd2;

    function automatic score_t sat_inc(input score_t value, input score_t ceiling);
        return (value >= ceiling) ? ceiling : value + score_t'(1);
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Half-period blink generator for the game-over display; phase starts lit (0) on restart.
module blink_timer #(
    parameter int unsigned BLINK_HALF  = 25_000_000,
    parameter int unsigned BLINK_COUNT = 6
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    input  logic restart,
    output logic phase,
    output logic done
);

    localparam int unsigned CW = $clog2(BLINK_HALF + 1);
    localparam int unsigned HW = $clog2(BLINK_COUNT + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BLINK_HALF - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(BLINK_COUNT - 1);

    logic [CW-1:0] cnt_q;
    logic [HW-1:0] halves_q;
    logic          phase_q;
    logic          half_end;

    assign half_end = (cnt_q == CNT_LAST);
    // Counters sit at zero while disabled, so done is only meaningful while counting.
    assign done     = half_end && (halves_q == HALF_LAST);
    assign phase    = phase_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            halves_q <= '0;
            phase_q  <= 1'b0;
        end else if (!enable || restart) begin
            cnt_q    <= '0;
            halves_q <= '0;
            phase_q  <= 1'b0;
        end else if (half_end) begin
            cnt_q    <= '0;
            halves_q <= halves_q + HW'(1);
            phase_q  <= ~phase_q;
        end else begin
            cnt_q    <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/score_tracker.sv
// Game score FSM: tracks the running score, best score and drives the registered display values.
module score_tracker
    import score_tracker_pkg::*;
#(
    parameter int unsigned MAX_SCORE   = 127,
    parameter int unsigned BLINK_HALF  = 25_000_000,
    parameter int unsigned BLINK_COUNT = 6
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         round_win,
    input  logic         round_fail,
    output logic [6:0]   disp_val,
    output logic         disp_blank,
    output logic [6:0]   high_score,
    output logic         new_high,
    output logic [1:0]   state
);

    localparam score_t MAX_S = score_t'(MAX_SCORE);

    logic [1:0] state_q, state_d;
    score_t     score_q, score_d;
    score_t     high_q, high_d;
    logic       new_high_q, new_high_d;
    score_t     disp_val_q, disp_val_d;
    logic       blink_enable, blink_restart;
    logic       blink_phase, blink_done;

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        high_d     = high_q;
        new_high_d = new_high_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = PLAY;
                    score_d    = '0;
                    new_high_d = 1'b0;
                end
            end
            PLAY: begin
                // Fail wins over a same-cycle win; start is ignored mid-game.
                if (round_fail) begin
                    state_d = OVER;
                    if (score_q > high_q) begin
                        high_d     = score_q;
                        new_high_d = 1'b1;
                    end
                end else if (round_win) begin
                    score_d = sat_inc(score_q, MAX_S);
                end
            end
            OVER: begin
                if (start) begin
                    state_d    = PLAY;
                    score_d    = '0;
                    new_high_d = 1'b0;
                end else if (blink_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Display follows the next state so it changes on the same edge as the cause.
    always_comb begin
        disp_val_d = (state_d == IDLE) ? high_d : score_d;
    end

    assign blink_enable  = (state_d == OVER);
    assign blink_restart = (state_d == OVER) && (state_q != OVER);

    blink_timer #(
        .BLINK_HALF  (BLINK_HALF),
        .BLINK_COUNT (BLINK_COUNT)
    ) u_blink_timer (
        .clk     (clk),
        .resetn  (resetn),
        .enable  (blink_enable),
        .restart (blink_restart),
        .phase   (blink_phase),
        .done    (blink_done)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            score_q    <= '0;
            high_q     <= '0;
            new_high_q <= 1'b0;
            disp_val_q <= '0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            high_q     <= high_d;
            new_high_q <= new_high_d;
            disp_val_q <= disp_val_d;
        end
    end

    assign disp_val   = disp_val_q;
    assign disp_blank = blink_phase;
    assign high_score = high_q;
    assign new_high   = new_high_q;
    assign state      = state_q;

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker with short blink timing and a small-ceiling instance.
module tb_score_tracker;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       round_win;
    logic       round_fail;
    logic [6:0] disp_val, high_score;
    logic       disp_blank, new_high;
    logic [1:0] state;
    logic [6:0] s_disp_val, s_high_score;
    logic       s_disp_blank, s_new_high;
    logic [1:0] s_state;

    int checks = 0;
    int errors = 0;

    score_tracker #(.MAX_SCORE(127), .BLINK_HALF(4), .BLINK_COUNT(6)) dut (
        .clk(clk), .resetn(resetn), .start(start), .round_win(round_win),
        .round_fail(round_fail), .disp_val(disp_val), .disp_blank(disp_blank),
        .high_score(high_score), .new_high(new_high), .state(state)
    );

    score_tracker #(.MAX_SCORE(10), .BLINK_HALF(4), .BLINK_COUNT(6)) dut_sat (
        .clk(clk), .resetn(resetn), .start(start), .round_win(round_win),
        .round_fail(round_fail), .disp_val(s_disp_val), .disp_blank(s_disp_blank),
        .high_score(s_high_score), .new_high(s_new_high), .state(s_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic w, input logic f);
        start = s;
        round_win = w;
        round_fail = f;
        step();
        start = 1'b0;
        round_win = 1'b0;
        round_fail = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start = 1'b0;
        round_win = 1'b0;
        round_fail = 1'b0;
        #3;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (disp_val !== 7'd0) begin errors++; $display("FAIL reset_disp got %0d want 0", disp_val); end
        checks++; if (high_score !== 7'd0) begin errors++; $display("FAIL reset_high got %0d want 0", high_score); end
        checks++; if (new_high !== 1'b0) begin errors++; $display("FAIL reset_new_high got %0b want 0", new_high); end
        checks++; if (disp_blank !== 1'b0) begin errors++; $display("FAIL reset_blank got %0b want 0", disp_blank); end
        @(negedge clk);
        resetn = 1'b1;
        step();
    endtask

    task automatic test_first_game();
        drive(1, 0, 0);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL g1_start_state got %0d want 1", state); end
        checks++; if (disp_val !== 7'd0) begin errors++; $display("FAIL g1_start_disp got %0d want 0", disp_val); end
        repeat (5) drive(0, 1, 0);
        checks++; if (disp_val !== 7'd5) begin errors++; $display("FAIL g1_score got %0d want 5", disp_val); end
        drive(0, 0, 1);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL g1_over_state got %0d want 2", state); end
        checks++; if (disp_val !== 7'd5) begin errors++; $display("FAIL g1_over_disp got %0d want 5", disp_val); end
        checks++; if (high_score !== 7'd5) begin errors++; $display("FAIL g1_high got %0d want 5", high_score); end
        checks++; if (new_high !== 1'b1) begin errors++; $display("FAIL g1_new_high got %0b want 1", new_high); end
    endtask

    task automatic test_blink_sequence();
        for (int k = 0; k < 24; k++) begin
            int exp_blank;
            exp_blank = (k / 4) % 2;
            checks++;
            if (disp_blank !== exp_blank[0] || state !== 2'd2) begin
                errors++;
                $display("FAIL blink_cycle_%0d got blank=%0b state=%0d want blank=%0b state=2",
                         k, disp_blank, state, exp_blank[0]);
            end
            step();
        end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL blink_end_state got %0d want 0", state); end
        checks++; if (disp_blank !== 1'b0) begin errors++; $display("FAIL blink_end_blank got %0b want 0", disp_blank); end
        checks++; if (disp_val !== 7'd5) begin errors++; $display("FAIL blink_end_disp got %0d want 5", disp_val); end
    endtask

    task automatic test_second_game();
        drive(1, 0, 0);
        repeat (3) drive(0, 1, 0);
        drive(0, 0, 1);
        checks++; if (high_score !== 7'd5) begin errors++; $display("FAIL g2_high got %0d want 5", high_score); end
        checks++; if (new_high !== 1'b0) begin errors++; $display("FAIL g2_new_high got %0b want 0", new_high); end
        checks++; if (disp_val !== 7'd3) begin errors++; $display("FAIL g2_disp got %0d want 3", disp_val); end
        repeat (23) step();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL g2_still_over got %0d want 2", state); end
        step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL g2_idle_state got %0d want 0", state); end
        checks++; if (disp_val !== 7'd5) begin errors++; $display("FAIL g2_idle_disp got %0d want 5", disp_val); end
    endtask

    task automatic test_simultaneous();
        drive(1, 0, 0);
        repeat (2) drive(0, 1, 0);
        drive(0, 1, 1);
        checks++; if (disp_val !== 7'd2) begin errors++; $display("FAIL simul_disp got %0d want 2", disp_val); end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL simul_state got %0d want 2", state); end
        checks++; if (high_score !== 7'd5) begin errors++; $display("FAIL simul_high got %0d want 5", high_score); end
    endtask

    task automatic test_abort_blink();
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 5) begin
                checks++; if (disp_blank !== 1'b1) begin errors++; $display("FAIL abort_blank5 got %0b want 1", disp_blank); end
            end
            if (k == 8) begin
                checks++; if (disp_blank !== 1'b0) begin errors++; $display("FAIL abort_blank8 got %0b want 0", disp_blank); end
            end
        end
        drive(1, 0, 0);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL abort_state got %0d want 1", state); end
        checks++; if (disp_val !== 7'd0) begin errors++; $display("FAIL abort_disp got %0d want 0", disp_val); end
        checks++; if (disp_blank !== 1'b0) begin errors++; $display("FAIL abort_blank got %0b want 0", disp_blank); end
    endtask

    task automatic test_ignored_inputs();
        int i;
        repeat (2) drive(0, 1, 0);
        drive(1, 0, 0);
        checks++; if (disp_val !== 7'd2 || state !== 2'd1) begin errors++; $display("FAIL play_start_ignored got disp=%0d state=%0d want disp=2 state=1", disp_val, state); end
        drive(0, 0, 1);
        drive(0, 1, 0);
        drive(0, 0, 1);
        checks++; if (disp_val !== 7'd2 || state !== 2'd2) begin errors++; $display("FAIL over_inputs_ignored got disp=%0d state=%0d want disp=2 state=2", disp_val, state); end
        i = 0;
        while (i < 40 && state !== 2'd0) begin
            step();
            i++;
        end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL over_timeout got state=%0d want 0", state); end
        drive(0, 1, 0);
        drive(0, 0, 1);
        checks++; if (state !== 2'd0 || disp_val !== 7'd5 || high_score !== 7'd5) begin errors++; $display("FAIL idle_inputs_ignored got state=%0d disp=%0d high=%0d want 0/5/5", state, disp_val, high_score); end
    endtask

    task automatic test_saturation();
        resetn = 1'b0;
        #2;
        @(negedge clk);
        resetn = 1'b1;
        drive(1, 0, 0);
        repeat (15) drive(0, 1, 0);
        checks++; if (s_disp_val !== 7'd10) begin errors++; $display("FAIL sat_disp got %0d want 10", s_disp_val); end
        checks++; if (disp_val !== 7'd15) begin errors++; $display("FAIL nosat_disp got %0d want 15", disp_val); end
        drive(0, 0, 1);
        checks++; if (s_high_score !== 7'd10 || s_new_high !== 1'b1 || s_state !== 2'd2) begin errors++; $display("FAIL sat_over got high=%0d new=%0b state=%0d want 10/1/2", s_high_score, s_new_high, s_state); end
    endtask

    task automatic test_reset_mid_play();
        drive(1, 0, 0);
        repeat (7) drive(0, 1, 0);
        checks++; if (disp_val !== 7'd7 || state !== 2'd1) begin errors++; $display("FAIL mid_play_pre got disp=%0d state=%0d want 7/1", disp_val, state); end
        #3;
        resetn = 1'b0;
        #2;
        checks++; if (disp_val !== 7'd0 || state !== 2'd0 || high_score !== 7'd0 || new_high !== 1'b0 || disp_blank !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got disp=%0d state=%0d high=%0d new=%0b blank=%0b want all 0",
                     disp_val, state, high_score, new_high, disp_blank);
        end
        start = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        step();
        start = 1'b0;
        checks++; if (state !== 2'd1 || high_score !== 7'd0) begin errors++; $display("FAIL release_start got state=%0d high=%0d want 1/0", state, high_score); end
    endtask

    initial begin
        test_reset();
        test_first_game();
        test_blink_sequence();
        test_second_game();
        test_simultaneous();
        test_abort_blink();
        test_ignored_inputs();
        test_saturation();
        test_reset_mid_play();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
